vga_rect_filler: RTL
====================

VGA_RECT_FILLER -- requirements
Module: vga_rect_filler

Interface
REQ-001 Parameter MAX_X, default 160, SHALL set the exclusive visible column limit; columns at or above it are clipped.
REQ-002 Parameter MAX_Y, default 120, SHALL set the exclusive visible row limit; rows at or above it are clipped.
REQ-003 Parameter COLOUR_WIDTH, default 3, SHALL set the colour bus width.
REQ-004 Port clock, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1: asynchronous, active-low reset.
REQ-006 Port go, input, 1: start request, sampled only in IDLE.
REQ-007 Port x_in, input, 8: rectangle origin column.
REQ-008 Port y_in, input, 7: rectangle origin row.
REQ-009 Port w_in, input, 8: width in pixels, 0..255.
REQ-010 Port h_in, input, 7: height in pixels, 0..127.
REQ-011 Port colour_in, input, COLOUR_WIDTH: fill colour.
REQ-012 Port x, output, 8: pixel column to the VGA adapter.
REQ-013 Port y, output, 7: pixel row to the VGA adapter.
REQ-014 Port colour, output, COLOUR_WIDTH: pixel colour to the VGA adapter.
REQ-015 Port plot, output, 1: write enable; x/y/colour are valid when it is high.
REQ-016 Port busy, output, 1: high in DRAW and DONE.
REQ-017 Port done, output, 1: single-cycle completion pulse.
REQ-018 All outputs SHALL be registered.

Function
REQ-019 The FSM SHALL have exactly three states: IDLE, DRAW and DONE.
REQ-020 In IDLE with go=1, the block SHALL latch x_in, y_in, w_in, h_in and colour_in, and clear the column counter (col) and row counter (row).
REQ-021 On a go accept, the FSM SHALL move to DRAW if w_in!=0 and h_in!=0; otherwise it SHALL move to DONE.
REQ-022 Each DRAW cycle SHALL present exactly one pixel: x=x0+col, y=y0+row, colour=latched colour.
REQ-023 The first pixel SHALL appear on the cycle after go is sampled (latency 1).
REQ-024 Scan order SHALL be row-major: col increments each cycle; at col=w-1, col wraps to 0 and row increments.
REQ-025 DRAW SHALL last exactly w*h cycles, and the FSM SHALL enter DONE after the pixel (w-1, h-1).
REQ-026 x0+col SHALL be computed 9 bits wide and y0+row 8 bits wide, with no wrap-around.
REQ-027 The x and y ports SHALL carry the low 8 and 7 bits of those sums respectively.
REQ-028 plot SHALL be 1 in DRAW only when x0+col<MAX_X and y0+row<MAX_Y; otherwise plot=0.
REQ-029 Clipped pixels SHALL still consume their cycle.
REQ-030 DONE SHALL last one cycle with done=1, then the FSM SHALL return to IDLE.
REQ-031 go SHALL be ignored while busy=1.
REQ-032 Input changes after go is accepted SHALL have no effect on the rectangle being drawn.
REQ-033 A go asserted in the same cycle that DONE returns to IDLE SHALL be ignored; go is sampled only when the FSM is in IDLE.
REQ-034 In IDLE and DONE, plot SHALL be 0, and x, y and colour SHALL hold their last values.

Reset
REQ-035 resetn=0 SHALL immediately force state=IDLE, x=0, y=0, colour=0, plot=0, busy=0, done=0 and clear all counters and latches, with no clock required.
REQ-036 A reset during DRAW SHALL abort the fill with no further plot pulses and no done pulse.
REQ-037 After resetn is released, a new go SHALL be required to start a fill.

Verification
REQ-038 go with x_in=10, y_in=20, w_in=3, h_in=2, colour=5 -> plot high for 6 consecutive cycles at (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) with colour=5, then done for 1 cycle, busy high for 7 cycles.
REQ-039 go with w_in=0, h_in=4 -> no plot, done 1 cycle after go, busy high for 1 cycle.
REQ-040 go with x_in=158, y_in=119, w_in=4, h_in=2 -> 8 DRAW cycles; plot=1 only at (158,119) and (159,119); done on the 9th cycle.
REQ-041 go re-pulsed and x_in changed mid-fill of a 4x4 rectangle -> pixel sequence unchanged, exactly 16 DRAW cycles, single done.
REQ-042 resetn low for 1 cycle at the 5th DRAW cycle of an 8x8 rectangle -> outputs zero asynchronously, no done; a subsequent go starts a fresh fill at (x0,y0).
REQ-043 Two back-to-back fills 1x1 each, with the second go held during the first -> the first completes, and the second starts only from go sampled in IDLE after DONE.

Source files
------------

// File: rtl/vga_rect_filler.sv
`default_nettype none
// ============================================================================
// Module      : vga_rect_filler
// Description : Fills an axis-aligned rectangle by streaming one pixel per
//               clock (row-major) to a VGA adapter, clipping off-screen pixels.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_rect_filler #(
    parameter int MAX_X        = 160,
    parameter int MAX_Y        = 120,
    parameter int COLOUR_WIDTH = 3
) (
    input  logic                    clock,
    input  logic                    resetn,
    input  logic                    go,
    input  logic [7:0]              x_in,
    input  logic [6:0]              y_in,
    input  logic [7:0]              w_in,
    input  logic [6:0]              h_in,
    input  logic [COLOUR_WIDTH-1:0] colour_in,
    output logic [7:0]              x,
    output logic [6:0]              y,
    output logic [COLOUR_WIDTH-1:0] colour,
    output logic                    plot,
    output logic                    busy,
    output logic                    done
);

    // Clip limits widened by one bit so the unwrapped sums compare cleanly
    localparam logic [9:0] c_max_x = MAX_X[9:0];
    localparam logic [8:0] c_max_y = MAX_Y[8:0];

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DRAW = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                  state_q,       state_d;
    logic [7:0]              x0_q,          x0_d;
    logic [6:0]              y0_q,          y0_d;
    logic [7:0]              w_q,           w_d;
    logic [6:0]              h_q,           h_d;
    logic [COLOUR_WIDTH-1:0] fill_colour_q, fill_colour_d;
    logic [7:0]              col_q,         col_d;
    logic [6:0]              row_q,         row_d;
    logic [7:0]              x_q,           x_d;
    logic [6:0]              y_q,           y_d;
    logic [COLOUR_WIDTH-1:0] colour_q,      colour_d;
    logic                    plot_q,        plot_d;
    logic                    busy_q,        busy_d;
    logic                    done_q,        done_d;

    // Next-state logic; output registers are loaded with the pixel that the
    // counters will point at next cycle, which gives first-pixel latency of 1
    logic       load_pix;
    logic [8:0] pix_x;
    logic [7:0] pix_y;

    always_comb begin
        state_d       = state_q;
        x0_d          = x0_q;
        y0_d          = y0_q;
        w_d           = w_q;
        h_d           = h_q;
        fill_colour_d = fill_colour_q;
        col_d         = col_q;
        row_d         = row_q;
        x_d           = x_q;
        y_d           = y_q;
        colour_d      = colour_q;
        plot_d        = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        load_pix      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (go) begin
                    x0_d          = x_in;
                    y0_d          = y_in;
                    w_d           = w_in;
                    h_d           = h_in;
                    fill_colour_d = colour_in;
                    col_d         = 8'd0;
                    row_d         = 7'd0;
                    busy_d        = 1'b1;
                    if ((w_in != 8'd0) && (h_in != 7'd0)) begin
                        state_d  = S_DRAW;
                        load_pix = 1'b1;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end
                end
            end
            S_DRAW: begin
                if (col_q == (w_q - 8'd1)) begin
                    if (row_q == (h_q - 7'd1)) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                    end else begin
                        col_d    = 8'd0;
                        row_d    = row_q + 7'd1;
                        load_pix = 1'b1;
                    end
                end else begin
                    col_d    = col_q + 8'd1;
                    load_pix = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Unwrapped pixel coordinates for the next presented pixel
        pix_x = {1'b0, x0_d} + {1'b0, col_d};
        pix_y = {1'b0, y0_d} + {1'b0, row_d};
        if (load_pix) begin
            x_d      = pix_x[7:0];
            y_d      = pix_y[6:0];
            colour_d = fill_colour_d;
            plot_d   = ({1'b0, pix_x} < c_max_x) && ({1'b0, pix_y} < c_max_y);
        end
    end

    // State, latches, counters and output registers with async active-low reset
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q       <= S_IDLE;
            x0_q          <= 8'd0;
            y0_q          <= 7'd0;
            w_q           <= 8'd0;
            h_q           <= 7'd0;
            fill_colour_q <= '0;
            col_q         <= 8'd0;
            row_q         <= 7'd0;
            x_q           <= 8'd0;
            y_q           <= 7'd0;
            colour_q      <= '0;
            plot_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            x0_q          <= x0_d;
            y0_q          <= y0_d;
            w_q           <= w_d;
            h_q           <= h_d;
            fill_colour_q <= fill_colour_d;
            col_q         <= col_d;
            row_q         <= row_d;
            x_q           <= x_d;
            y_q           <= y_d;
            colour_q      <= colour_d;
            plot_q        <= plot_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
        end
    end

    assign x      = x_q;
    assign y      = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule
`default_nettype wire
